// File: rtl/reset_sync_pkg.sv
// Shared constants and helpers for the reset synchronizer.
// Default parameter values and the counter-width rule live here.
package reset_sync_pkg;

  localparam int MIN_SYNC_STAGES     = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_STRETCH_CYCLES  = 4;
  localparam int DEF_FILTER_CYCLES   = 2;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val <= 0) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_synchronizer_chain.sv
// Generic N-stage single-bit synchronizer with a configurable reset value.
// Module name: sync_bit_chain.
module sync_bit_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  assign chain_d = {chain_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_synchronizer.sv
// Clock-aligned active-high reset with a minimum-assertion stretch and a
// release pulse. Optional request glitch filter: define RESET_SYNC_FILTER_EN.
module reset_synchronizer
  import reset_sync_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_rst,
  output logic sync_rst,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYCLES);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
      $error("reset_synchronizer: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("reset_synchronizer: FILTER_CYCLES must be at least 1");
    end
  endgenerate

  logic req_s;
  logic req_eff;

  sync_bit_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_req_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (async_rst),
    .q_o   (req_s)
  );

`ifdef RESET_SYNC_FILTER_EN
  localparam int QUAL_W = cnt_width(FILTER_CYCLES);
  localparam logic [QUAL_W-1:0] QUAL_MAX = QUAL_W'(FILTER_CYCLES);

  logic [QUAL_W-1:0] qual_q, qual_d;

  // Saturating run-length of req_s; a request counts only once it saturates.
  always_comb begin
    qual_d = qual_q;
    if (!req_s) begin
      qual_d = '0;
    end else if (qual_q != QUAL_MAX) begin
      qual_d = qual_q + QUAL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qual_q <= '0;
    end else begin
      qual_q <= qual_d;
    end
  end

  assign req_eff = req_s & (qual_q == QUAL_MAX);
`else
  assign req_eff = req_s;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_rst_q, sync_rst_d;
  logic             release_q, release_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req_eff) begin
      cnt_d = STRETCH_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    sync_rst_d = req_eff | (cnt_q != '0);
    release_d  = sync_rst_q & ~sync_rst_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= STRETCH_LD;
      sync_rst_q <= 1'b1;
      release_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sync_rst_q <= sync_rst_d;
      release_q  <= release_d;
    end
  end

  assign sync_rst      = sync_rst_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_reset_synchronizer.sv
// Scoreboard bench for reset_synchronizer: a windowed timing model predicts
// sync_rst/release_pulse per edge; build with RESET_SYNC_FILTER_EN for filter cases.
module tb_reset_synchronizer;

  localparam int SYNC    = 2;
  localparam int STRETCH = 4;
  localparam int FILT    = 2;
  localparam int REL_LAT = SYNC + STRETCH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic async_rst = 1'b0;
  logic sync_rst;
  logic release_pulse;

  always #5 clk = ~clk;

  reset_synchronizer #(
    .SYNC_STAGES    (SYNC),
    .STRETCH_CYCLES (STRETCH),
    .FILTER_CYCLES  (FILT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .async_rst     (async_rst),
    .sync_rst      (sync_rst),
    .release_pulse (release_pulse)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       raw_h[$];   // request as sampled at each edge (rst counts as request)
  logic       qual_h[$];  // request after optional qualification
  logic       prev_sync = 1'b1;
  logic [1:0] exp_q[$];   // {sync_rst, release_pulse} expected after the next edge

  // sync_rst after edge n is high iff a qualified request was sampled at an
  // edge m with SYNC <= n-m <= SYNC+STRETCH; rst forces it high.
  task automatic push_expect();
    logic s, q, e_sync, e_rel;
    s = rst | async_rst;
    raw_h.push_back(s);
    q = s;
`ifdef RESET_SYNC_FILTER_EN
    if (raw_h.size() < FILT + 1) q = 1'b0;
    else for (int i = 0; i <= FILT; i++) q = q & raw_h[raw_h.size()-1-i];
`endif
    qual_h.push_back(q);
    e_sync = 1'b0;
    for (int k = SYNC; k <= SYNC + STRETCH; k++)
      if (qual_h.size() > k && qual_h[qual_h.size()-1-k]) e_sync = 1'b1;
    if (rst) e_sync = 1'b1;
    e_rel = !rst && prev_sync && !e_sync;
    prev_sync = e_sync;
    exp_q.push_back({e_sync, e_rel});
    while (raw_h.size() > 32) void'(raw_h.pop_front());
    while (qual_h.size() > 32) void'(qual_h.pop_front());
  endtask

  task automatic test_reset();
    logic [1:0] e;
    int fall_at = -1;
    int pulses = 0;
    rst = 1'b1; async_rst = 1'b0;
    for (int c = 0; c < 3 + 10; c++) begin
      rst = (c < 3);
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
      if (c >= 3 && fall_at < 0 && sync_rst === 1'b0) fall_at = c - 2;
      if (release_pulse === 1'b1) pulses++;
    end
    n_cmp++;
    if (fall_at != REL_LAT) begin
      n_bad++;
      $display("FAIL reset_release_edge got %0d want %0d", fall_at, REL_LAT);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL reset_release_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_assert();
    logic [1:0] e;
    int rise_at = -1;
    for (int c = 0; c < 12; c++) begin
      async_rst = 1'b0;
      if (c >= 2) begin
        #4 async_rst = 1'b1;  // rises mid-cycle
      end
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL assert cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
      if (c >= 2 && rise_at < 0 && sync_rst === 1'b1) rise_at = c - 1;
    end
    n_cmp++;
    if (rise_at != SYNC + 1) begin
      n_bad++;
      $display("FAIL assert_edge got %0d want %0d", rise_at, SYNC + 1);
    end
  endtask

  task automatic test_release();
    logic [1:0] e;
    int fall_at = -1;
    for (int c = 0; c < 10; c++) begin
      async_rst = 1'b0;
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL release cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
      if (fall_at < 0 && sync_rst === 1'b0) fall_at = c + 1;
    end
    n_cmp++;
    if (fall_at != REL_LAT) begin
      n_bad++;
      $display("FAIL release_edge got %0d want %0d", fall_at, REL_LAT);
    end
  endtask

  // 4 high, 3 low (into the stretch), 2 high, then low until release.
  task automatic test_back_to_back();
    logic [1:0] e;
    int fall_at = -1;
    int gaps = 0;
    for (int c = 0; c < 20; c++) begin
      async_rst = (c < 4) || (c == 7) || (c == 8);
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
      if (c >= SYNC && c < 9 && sync_rst !== 1'b1) gaps++;
      if (c >= 9 && fall_at < 0 && sync_rst === 1'b0) fall_at = c - 8;
    end
    n_cmp++;
    if (gaps != 0 || fall_at != REL_LAT) begin
      n_bad++;
      $display("FAIL back_to_back_release got gaps=%0d edge=%0d want gaps=0 edge=%0d",
               gaps, fall_at, REL_LAT);
    end
  endtask

  // Pulse, let the stretch begin, then pulse rst for 2 cycles.
  task automatic test_rst_mid_stretch();
    logic [1:0] e;
    int fall_at = -1;
    for (int c = 0; c < 20; c++) begin
      async_rst = (c < 4);
      rst = (c == 7) || (c == 8);
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL rst_mid_stretch cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
      if (c >= 9 && fall_at < 0 && sync_rst === 1'b0) fall_at = c - 8;
    end
    n_cmp++;
    if (fall_at != REL_LAT) begin
      n_bad++;
      $display("FAIL rst_mid_stretch_edge got %0d want %0d", fall_at, REL_LAT);
    end
  endtask

`ifdef RESET_SYNC_FILTER_EN
  // Reset and idle without checking so the bench model and DUT both settle low.
  task automatic settle_reset();
    for (int c = 0; c < 16; c++) begin
      rst = (c < 3);
      async_rst = 1'b0;
      push_expect();
      @(posedge clk); #1;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_filter_short();
    logic [1:0] e;
    for (int c = 0; c < 10; c++) begin
      async_rst = (c == 0);
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e || sync_rst !== 1'b0) begin
        n_bad++;
        $display("FAIL filter_short cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
    end
  endtask

  task automatic test_filter_long();
    logic [1:0] e;
    int rise_at = -1;
    for (int c = 0; c < 16; c++) begin
      async_rst = (c < 5);
      push_expect();
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({sync_rst, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL filter_long cyc=%0d got sync=%b rel=%b want sync=%b rel=%b",
                 c, sync_rst, release_pulse, e[1], e[0]);
      end
      if (rise_at < 0 && sync_rst === 1'b1) rise_at = c + 1;
    end
    n_cmp++;
    if (rise_at != SYNC + FILT + 1) begin
      n_bad++;
      $display("FAIL filter_long_edge got %0d want %0d", rise_at, SYNC + FILT + 1);
    end
  endtask
`endif

  initial begin
`ifdef RESET_SYNC_FILTER_EN
    settle_reset();
    test_filter_short();
    test_filter_long();
`else
    test_reset();
    test_assert();
    test_release();
    test_back_to_back();
    test_rst_mid_stretch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
